stack_queue_engine: RTL and testbench
=====================================

// Module: stack_queue_engine
// PURPOSE
//   Parametrised successor to the 3-entry stack machine: DEPTH-entry word store, FIFO or LIFO
//   selected at elaboration, with the same 2-bit op set (pop / push-low / push / push-split).
//   Adds explicit op strobe, full/empty/count status, sticky overflow/underflow flags and
//   registered pop data. Sits between the host data bus and the PS compute datapath.
// PARAMETERS
//   DATA_WIDTH  16  word width; must be even, >= 2
//   DEPTH       8   number of entries; >= 2, need not be a power of two
//   LIFO        0   0 = FIFO order, 1 = LIFO order
// PORTS
//   clk       in   1                      single clock, rising edge
//   rst       in   1                      synchronous, active-high reset
//   ctl_vld   in   1                      op strobe; ctl is ignored when low
//   ctl       in   2                      00 POP, 01 PUSH_LO, 10 PUSH, 11 PUSH_SPLIT
//   DATA_in   in   DATA_WIDTH             push operand
//   clr_err   in   1                      clears ovf_err/unf_err (one-cycle pulse)
//   DATA_out  out  DATA_WIDTH             last popped word, registered, held until next pop
//   out_vld   out  1                      one-cycle pulse: DATA_out updated this cycle
//   o_wait    out  1                      high when count > DEPTH-2 (PUSH_SPLIT would be refused)
//   full      out  1                      count == DEPTH
//   empty     out  1                      count == 0
//   count     out  $clog2(DEPTH+1)        current occupancy
//   ovf_err   out  1                      sticky: a push was refused
//   unf_err   out  1                      sticky: POP issued while empty
// BEHAVIOUR
//   - Reset: count=0, pointers=0, DATA_out=0, out_vld=0, ovf_err=0, unf_err=0; storage not cleared.
//     Reset mid-operation discards all contents; an op presented in the reset cycle is ignored.
//   - One op per cycle; all ops take effect at the clock edge where ctl_vld=1.
//   - PUSH: writes DATA_in. PUSH_LO: writes {zeros, DATA_in[DATA_WIDTH/2-1:0]}.
//   - PUSH_SPLIT: writes two entries in one cycle: first {zeros, low half}, then {zeros, high half};
//     FIFO pops low then high; LIFO pops high then low. count += 2.
//   - Admission: PUSH/PUSH_LO need count < DEPTH; PUSH_SPLIT needs count <= DEPTH-2. A refused push
//     changes nothing except setting ovf_err (never a partial split write).
//   - POP: when count > 0, next-cycle DATA_out = FIFO head (oldest) or LIFO top (newest), out_vld=1,
//     count -= 1. When empty: unf_err set, DATA_out held, out_vld=0. Latency 1 cycle.
//   - No same-cycle bypass: data pushed at edge N is poppable by an op presented at edge N+1.
//   - FIFO: rd_ptr/wr_ptr wrap from DEPTH-1 to 0 (explicit compare, not power-of-two masking);
//     split write uses wr_ptr and wr_ptr+1 with wrap. LIFO: top index = count-1.
//   - Status (full/empty/o_wait/count) is combinational from the count register; it reflects state
//     after the last edge.
//   - Error flags: set has priority over clr_err in the same cycle; otherwise clr_err clears both.
//   - ctl_vld=0: no state change, out_vld=0.
// STRUCTURE
//   - Shared include stack_defs.vh: localparams OP_POP=2'b00, OP_PUSH_LO=2'b01, OP_PUSH=2'b10,
//     OP_PUSH_SPLIT=2'b11; reused by the host sequencer and the bench.
//   - Single module; storage as reg array; pointer-increment-with-wrap as a local function.
//     No sub-module: control and array together are small.
// TESTING (DATA_WIDTH=16, DEPTH=4, both LIFO=0 and LIFO=1)
//   - Reset then PUSH 0x1234, 0xABCD; POP x2 -> FIFO: 0x1234,0xABCD; LIFO: 0xABCD,0x1234; out_vld
//     pulses 1 cycle after each POP; empty=1 after.
//   - PUSH_SPLIT 0xBEEF -> count=2; POP x2 -> FIFO 0x00EF,0x00BE; LIFO 0x00BE,0x00EF.
//   - PUSH_LO 0x5A3C -> popped word 0x003C.
//   - Fill with 3 PUSH -> o_wait=1; PUSH_SPLIT 0x1111 -> refused, ovf_err=1, count=3; PUSH 0x7777
//     -> full=1; further PUSH -> ovf_err stays 1, count=4.
//   - POP on empty -> unf_err=1, DATA_out unchanged, out_vld=0; clr_err -> both flags 0;
//     clr_err coincident with another underflow -> unf_err stays 1.
//   - FIFO wrap: 6 interleaved push/pop rounds crossing index 3->0 preserve order;
//     rst asserted with count=3 -> count=0, empty=1, DATA_out=0 next cycle.

Source files
------------

// File: rtl/stack_queue_engine_pkg.sv
// Shared op encoding for the stack/queue engine, its host sequencer and bench.
package stack_queue_engine_pkg;

  localparam logic [1:0] OP_POP        = 2'b00;
  localparam logic [1:0] OP_PUSH_LO    = 2'b01;
  localparam logic [1:0] OP_PUSH       = 2'b10;
  localparam logic [1:0] OP_PUSH_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    POP        = OP_POP,
    PUSH_LO    = OP_PUSH_LO,
    PUSH       = OP_PUSH,
    PUSH_SPLIT = OP_PUSH_SPLIT
  } op_e;

endpackage

// File: rtl/stack_queue_engine.sv
// DEPTH-entry word store, FIFO or LIFO order, with split pushes,
// occupancy status, sticky error flags and registered pop data.
module stack_queue_engine
  import stack_queue_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter bit LIFO       = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctl_vld,
  input  logic [1:0]                   ctl,
  input  logic [DATA_WIDTH-1:0]        DATA_in,
  input  logic                         clr_err,
  output logic [DATA_WIDTH-1:0]        DATA_out,
  output logic                         out_vld,
  output logic                         o_wait,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf_err,
  output logic                         unf_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int HW = DATA_WIDTH / 2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  op_e                   op;
  logic [CW-1:0]         cnt_p1;
  logic [CW-1:0]         cnt_m1;
  logic [DATA_WIDTH-1:0] lo_word;
  logic [DATA_WIDTH-1:0] hi_word;
  logic                  room1;
  logic                  room2;

  logic                  we0;
  logic                  we1;
  logic [PW-1:0]         wa0;
  logic [PW-1:0]         wa1;
  logic [DATA_WIDTH-1:0] wd0;
  logic [DATA_WIDTH-1:0] wd1;
  logic [PW-1:0]         ra;
  logic                  pop_ok;
  logic                  pop_ref;
  logic                  push_ref;

  // Pointer wrap by compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign op      = op_e'(ctl);
  assign cnt_p1  = count + CW'(1);
  assign cnt_m1  = count - CW'(1);
  assign lo_word = {{HW{1'b0}}, DATA_in[HW-1:0]};
  assign hi_word = {{HW{1'b0}}, DATA_in[DATA_WIDTH-1:HW]};
  assign room1   = count < CW'(DEPTH);
  assign room2   = count <= CW'(DEPTH - 2);

  assign o_wait  = count > CW'(DEPTH - 2);
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;

  // LIFO grows upward from index 0, so the top sits at count-1.
  assign wa0 = LIFO ? count[PW-1:0]  : wr_ptr;
  assign wa1 = LIFO ? cnt_p1[PW-1:0] : ptr_inc(wr_ptr);
  assign ra  = LIFO ? cnt_m1[PW-1:0] : rd_ptr;

  always_comb begin
    we0      = 1'b0;
    we1      = 1'b0;
    wd0      = DATA_in;
    wd1      = hi_word;
    pop_ok   = 1'b0;
    pop_ref  = 1'b0;
    push_ref = 1'b0;
    if (ctl_vld) begin
      unique case (op)
        POP: begin
          if (!empty) pop_ok  = 1'b1;
          else        pop_ref = 1'b1;
        end
        PUSH_LO: begin
          wd0 = lo_word;
          if (room1) we0      = 1'b1;
          else       push_ref = 1'b1;
        end
        PUSH: begin
          if (room1) we0      = 1'b1;
          else       push_ref = 1'b1;
        end
        PUSH_SPLIT: begin
          wd0 = lo_word;
          if (room2) begin
            we0 = 1'b1;
            we1 = 1'b1;
          end else begin
            push_ref = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      DATA_out <= '0;
      out_vld  <= 1'b0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
    end else begin
      out_vld <= pop_ok;
      if (pop_ok) begin
        DATA_out <= mem[ra];
        rd_ptr   <= ptr_inc(rd_ptr);
        count    <= cnt_m1;
      end else if (we1) begin
        wr_ptr   <= ptr_inc(ptr_inc(wr_ptr));
        count    <= count + CW'(2);
      end else if (we0) begin
        wr_ptr   <= ptr_inc(wr_ptr);
        count    <= cnt_p1;
      end
      // A new error outranks a clear arriving in the same cycle.
      if (push_ref)     ovf_err <= 1'b1;
      else if (clr_err) ovf_err <= 1'b0;
      if (pop_ref)      unf_err <= 1'b1;
      else if (clr_err) unf_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stack_queue_engine.sv
// Bench: FIFO and LIFO instances driven together, checked against
// queue-based reference models with directed and random ops.
module tb_stack_queue_engine;
  import stack_queue_engine_pkg::*;

  localparam int DW = 16;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ctl_vld = 1'b0;
  logic [1:0]    ctl = 2'b00;
  logic [DW-1:0] din = '0;
  logic          clr_err = 1'b0;

  logic [DW-1:0] f_dout, l_dout;
  logic          f_ovld, l_ovld;
  logic          f_wait, l_wait;
  logic          f_full, l_full;
  logic          f_empty, l_empty;
  logic [2:0]    f_cnt, l_cnt;
  logic          f_ovf, l_ovf;
  logic          f_unf, l_unf;

  always #5 clk = ~clk;

  stack_queue_engine #(.DATA_WIDTH(DW), .DEPTH(DP), .LIFO(1'b0)) u_fifo (
    .clk(clk), .rst(rst), .ctl_vld(ctl_vld), .ctl(ctl),
    .DATA_in(din), .clr_err(clr_err), .DATA_out(f_dout),
    .out_vld(f_ovld), .o_wait(f_wait), .full(f_full),
    .empty(f_empty), .count(f_cnt), .ovf_err(f_ovf),
    .unf_err(f_unf)
  );

  stack_queue_engine #(.DATA_WIDTH(DW), .DEPTH(DP), .LIFO(1'b1)) u_lifo (
    .clk(clk), .rst(rst), .ctl_vld(ctl_vld), .ctl(ctl),
    .DATA_in(din), .clr_err(clr_err), .DATA_out(l_dout),
    .out_vld(l_ovld), .o_wait(l_wait), .full(l_full),
    .empty(l_empty), .count(l_cnt), .ovf_err(l_ovf),
    .unf_err(l_unf)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] qf[$];
  logic [DW-1:0] ql[$];
  logic [DW-1:0] m_fdout = '0;
  logic [DW-1:0] m_ldout = '0;
  logic          m_vld = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit v, input logic [1:0] op,
                       input logic [DW-1:0] d, input bit c, input bit r);
    bit os, us;
    int n;
    os = 1'b0;
    us = 1'b0;
    m_vld = 1'b0;
    if (r) begin
      qf.delete();
      ql.delete();
      m_fdout = '0;
      m_ldout = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    n = qf.size();
    if (v) begin
      case (op)
        OP_POP: begin
          if (n == 0) us = 1'b1;
          else begin
            m_fdout = qf.pop_front();
            m_ldout = ql.pop_back();
            m_vld = 1'b1;
          end
        end
        OP_PUSH, OP_PUSH_LO: begin
          if (n >= DP) os = 1'b1;
          else begin
            qf.push_back(op == OP_PUSH ? d : {8'h00, d[7:0]});
            ql.push_back(op == OP_PUSH ? d : {8'h00, d[7:0]});
          end
        end
        default: begin
          if (n + 2 > DP) os = 1'b1;
          else begin
            qf.push_back({8'h00, d[7:0]});
            qf.push_back({8'h00, d[15:8]});
            ql.push_back({8'h00, d[7:0]});
            ql.push_back({8'h00, d[15:8]});
          end
        end
      endcase
    end
    m_ovf = os ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf = us ? 1'b1 : (c ? 1'b0 : m_unf);
  endtask

  task automatic check_all();
    int n;
    n = qf.size();
    chk("f_count", 32'(f_cnt), 32'(n));
    chk("l_count", 32'(l_cnt), 32'(n));
    chk("f_empty", 32'(f_empty), 32'(n == 0));
    chk("l_empty", 32'(l_empty), 32'(n == 0));
    chk("f_full", 32'(f_full), 32'(n == DP));
    chk("l_full", 32'(l_full), 32'(n == DP));
    chk("f_wait", 32'(f_wait), 32'(n > DP - 2));
    chk("l_wait", 32'(l_wait), 32'(n > DP - 2));
    chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
    chk("l_ovf", 32'(l_ovf), 32'(m_ovf));
    chk("f_unf", 32'(f_unf), 32'(m_unf));
    chk("l_unf", 32'(l_unf), 32'(m_unf));
    chk("f_ovld", 32'(f_ovld), 32'(m_vld));
    chk("l_ovld", 32'(l_ovld), 32'(m_vld));
    chk("f_dout", 32'(f_dout), 32'(m_fdout));
    chk("l_dout", 32'(l_dout), 32'(m_ldout));
  endtask

  task automatic step(input bit v, input logic [1:0] op,
                      input logic [DW-1:0] d, input bit c, input bit r);
    @(negedge clk);
    ctl_vld = v;
    ctl = op;
    din = d;
    clr_err = c;
    rst = r;
    @(posedge clk);
    model(v, op, d, c, r);
    #1;
    check_all();
  endtask

  task automatic op1(input logic [1:0] op, input logic [DW-1:0] d);
    step(1'b1, op, d, 1'b0, 1'b0);
  endtask

  initial begin
    step(1'b1, OP_PUSH, 16'hDEAD, 1'b0, 1'b1);
    step(1'b0, OP_POP, 16'h0, 1'b0, 1'b0);

    op1(OP_PUSH, 16'h1234);
    op1(OP_PUSH, 16'hABCD);
    op1(OP_POP, 16'h0);
    chk("dir_f_pop1", 32'(f_dout), 32'h1234);
    chk("dir_l_pop1", 32'(l_dout), 32'hABCD);
    op1(OP_POP, 16'h0);
    chk("dir_f_pop2", 32'(f_dout), 32'hABCD);
    chk("dir_l_pop2", 32'(l_dout), 32'h1234);
    step(1'b0, OP_POP, 16'h0, 1'b0, 1'b0);
    chk("dir_vld_drop", 32'(f_ovld), 32'h0);

    op1(OP_PUSH_SPLIT, 16'hBEEF);
    chk("dir_split_cnt", 32'(f_cnt), 32'd2);
    op1(OP_POP, 16'h0);
    chk("dir_f_sp1", 32'(f_dout), 32'h00EF);
    chk("dir_l_sp1", 32'(l_dout), 32'h00BE);
    op1(OP_POP, 16'h0);
    chk("dir_f_sp2", 32'(f_dout), 32'h00BE);
    chk("dir_l_sp2", 32'(l_dout), 32'h00EF);

    op1(OP_PUSH_LO, 16'h5A3C);
    op1(OP_POP, 16'h0);
    chk("dir_lo", 32'(f_dout), 32'h003C);

    op1(OP_PUSH, 16'h0001);
    op1(OP_PUSH, 16'h0002);
    op1(OP_PUSH, 16'h0003);
    chk("dir_wait", 32'(f_wait), 32'h1);
    op1(OP_PUSH_SPLIT, 16'h1111);
    chk("dir_split_ref", 32'(l_ovf), 32'h1);
    chk("dir_split_cnt3", 32'(l_cnt), 32'd3);
    op1(OP_PUSH, 16'h7777);
    chk("dir_full", 32'(f_full), 32'h1);
    op1(OP_PUSH, 16'h8888);
    chk("dir_full_cnt", 32'(f_cnt), 32'd4);
    repeat (4) op1(OP_POP, 16'h0);
    chk("dir_f_last", 32'(f_dout), 32'h7777);
    chk("dir_l_last", 32'(l_dout), 32'h0001);

    op1(OP_POP, 16'h0);
    chk("dir_unf", 32'(f_unf), 32'h1);
    chk("dir_unf_hold", 32'(f_dout), 32'h7777);
    step(1'b0, OP_POP, 16'h0, 1'b1, 1'b0);
    chk("dir_clr", 32'({f_ovf, f_unf}), 32'h0);
    op1(OP_POP, 16'h0);
    step(1'b1, OP_POP, 16'h0, 1'b1, 1'b0);
    chk("dir_unf_prio", 32'(f_unf), 32'h1);

    step(1'b0, OP_POP, 16'h0, 1'b1, 1'b1);
    op1(OP_PUSH, 16'hA000);
    op1(OP_PUSH, 16'hA001);
    op1(OP_PUSH, 16'hA002);
    for (int i = 0; i < 6; i++) begin
      op1(OP_PUSH, 16'hB000 + 16'(i));
      op1(OP_POP, 16'h0);
    end
    chk("dir_wrap_f", 32'(f_dout), 32'hB002);
    step(1'b1, OP_POP, 16'h0, 1'b0, 1'b1);
    chk("dir_rst_cnt", 32'(f_cnt), 32'd0);
    chk("dir_rst_dout", 32'(l_dout), 32'h0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom % 10) < 8, 2'($urandom), 16'($urandom),
           ($urandom % 10) == 0, ($urandom % 60) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
